reduce_gate_pipe: RTL and testbench



---
 rtl/reduce_gate_pipe.sv | 135 +++++++++++++
 tb/tb_reduce_gate_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_gate_pipe.sv
// Pipelined multi-channel reduction gate: one opcode per transaction selects
// AND/NAND/OR/NOR/XOR/XNOR/BUF/NOT over the masked inputs of every channel.
module reduce_gate_pipe #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 6,
  parameter int STAGES   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic [CHANNELS*WIDTH-1:0]    in_mask,
  input  logic [2:0]                   in_op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS-1:0]          out_data,
  output logic [2:0]                   out_op,
  output logic                         busy
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_BUF  = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  logic [CHANNELS-1:0] w_res;

  // Masked-out bits are forced to the identity of each reduction, so an X or Z
  // sitting on a masked input never reaches the result.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_m;
    logic             w_and;
    logic             w_or;
    logic             w_xor;
    logic             w_b0;
    logic             w_bit;

    assign w_d   = in_data[c*WIDTH +: WIDTH];
    assign w_m   = in_mask[c*WIDTH +: WIDTH];
    assign w_and = &(w_d | ~w_m);
    assign w_or  = |(w_d & w_m);
    assign w_xor = ^(w_d & w_m);
    // XOR with 0 turns a floating Z into X, matching the gate-table behaviour.
    assign w_b0  = w_d[0] ^ 1'b0;

    always_comb begin
      w_bit = 1'b0;
      case (op_e'(in_op))
        OP_AND:  w_bit = w_and;
        OP_NAND: w_bit = ~w_and;
        OP_OR:   w_bit = w_or;
        OP_NOR:  w_bit = ~w_or;
        OP_XOR:  w_bit = w_xor;
        OP_XNOR: w_bit = ~w_xor;
        OP_BUF:  w_bit = w_b0;
        OP_NOT:  w_bit = ~w_b0;
        default: w_bit = 1'b0;
      endcase
    end

    assign w_res[c] = w_bit;
  end

  logic [STAGES-1:0]   r_valid;
  logic [CHANNELS-1:0] r_res [STAGES];
  logic [2:0]          r_op  [STAGES];
  logic [STAGES-1:0]   w_adv;
  logic [STAGES-1:0]   w_load;
  logic [CHANNELS-1:0] w_nres [STAGES];
  logic [2:0]          w_nop  [STAGES];
  logic                w_accept;

  // Handshake: a beat moves on a port when valid and ready are both high at
  // posedge clk; out_valid/out_data/out_op stay frozen while out_ready is low.
  // A stage moves forward when any stage downstream of it is empty (the chain
  // between closes up) or when the whole tail is full and out_ready is high.
  always_comb begin : adv_calc
    logic w_hole;
    w_hole = 1'b0;
    w_adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k] = r_valid[k] & (out_ready | w_hole);
      w_hole   = w_hole | ~r_valid[k];
    end
  end

  assign in_ready = ~r_valid[0] | w_adv[0];
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_load    = '0;
    w_load[0] = w_accept;
    w_nres[0] = w_res;
    w_nop[0]  = in_op;
    for (int k = 1; k < STAGES; k++) begin
      w_load[k] = w_adv[k-1];
      w_nres[k] = r_res[k-1];
      w_nop[k]  = r_op[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_res[k] <= '0;
        r_op[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= 1'b1;
          r_res[k]   <= w_nres[k];
          r_op[k]    <= w_nop[k];
        end else if (w_adv[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_res[STAGES-1];
  assign out_op    = r_op[STAGES-1];
  assign busy      = |r_valid;

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Directed bench for reduce_gate_pipe: gate functions, empty masks, 4-state
// inputs, throughput, backpressure and mid-stall reset, with hand-derived values.
module tb_reduce_gate_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] in_data;
  logic [29:0] in_mask;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_data;
  logic [2:0]  out_op;
  logic        busy;

  reduce_gate_pipe #(.WIDTH(5), .CHANNELS(6), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op),
    .busy      (busy)
  );

  typedef struct packed {
    logic [29:0] d;
    logic [29:0] m;
    logic [2:0]  op;
  } txn_t;

  localparam logic [29:0] FULL = 30'h3FFF_FFFF;
  // channel 5 .. channel 0
  localparam logic [29:0] BASE = {5'b00011, 5'b11110, 5'b10110, 5'b00001, 5'b11111, 5'b00000};

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_out    = 0;
  bit         four_state;
  logic [5:0] exp_tab [8];
  txn_t       pend_q [$];
  logic [8:0] exp_q [$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction through an empty pipeline with out_ready high.
  task automatic single(input string tag, input logic [29:0] d, input logic [29:0] m,
                        input logic [2:0] op, input logic [5:0] exp);
    out_ready = 1'b1;
    in_data   = d;
    in_mask   = m;
    in_op     = op;
    in_valid  = 1'b1;
    #1;
    check({tag, "/in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check({tag, "/early_valid"}, out_valid, 1'b0);
    tick();
    check({tag, "/valid"}, out_valid, 1'b1);
    check({tag, "/data"}, out_data, exp);
    check({tag, "/op"}, out_op, op);
    tick();
    check({tag, "/retired"}, out_valid, 1'b0);
  endtask

  task automatic xcase(input string tag, input logic [2:0] op, input logic [4:0] m0,
                       input logic [4:0] v0, input logic [4:0] u0, input bit use_z,
                       input logic e_bit, input bit e_x, input logic e2, input logic e_rest);
    logic [4:0] d0;
    logic       e0;
    for (int b = 0; b < 5; b++) begin
      if (u0[b]) d0[b] = four_state ? (use_z ? 1'bz : 1'bx) : 1'b0;
      else       d0[b] = v0[b];
    end
    e0 = four_state ? (e_x ? 1'bx : e_bit) : e2;
    single(tag, {25'b0, d0}, {25'b0, m0}, op, {{5{e_rest}}, e0});
  endtask

  // driver: one cycle of the queued input stream plus output scoreboard
  task automatic step();
    logic fire_in;
    logic fire_out;
    if (pend_q.size() != 0) begin
      in_valid = 1'b1;
      in_data  = pend_q[0].d;
      in_mask  = pend_q[0].m;
      in_op    = pend_q[0].op;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    fire_in  = in_valid & in_ready;
    fire_out = out_valid & out_ready;
    if (fire_out) begin
      if (exp_q.size() == 0) begin
        check("extra_out", out_valid, 1'b0);
      end else begin
        check("order", {out_op, out_data}, exp_q.pop_front());
        n_out++;
      end
    end
    tick();
    if (fire_in) pend_q.delete(0);
  endtask

  task automatic enqueue(input logic [2:0] op);
    txn_t t;
    t.d  = BASE;
    t.m  = FULL;
    t.op = op;
    pend_q.push_back(t);
    exp_q.push_back({op, exp_tab[op]});
  endtask

  initial begin
    logic probe;
    probe      = 1'bx;
    four_state = $isunknown(probe);

    exp_tab[0] = 6'h02; exp_tab[1] = 6'h3D; exp_tab[2] = 6'h3E; exp_tab[3] = 6'h01;
    exp_tab[4] = 6'h0E; exp_tab[5] = 6'h31; exp_tab[6] = 6'h26; exp_tab[7] = 6'h19;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mask   = '0;
    in_op     = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst/out_valid", out_valid, 1'b0);
    check("rst/busy", busy, 1'b0);
    check("rst/out_data", out_data, 6'h00);
    check("rst/out_op", out_op, 3'd0);
    rst_n = 1'b1;
    #1;
    check("rst/in_ready", in_ready, 1'b1);

    single("nor_w1to5", {5'b00100, 20'b0, 5'b00000},
           {5'b11111, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00001}, 3'd3, 6'b011111);

    single("empty_and",  BASE, '0, 3'd0, 6'h3F);
    single("empty_nor",  BASE, '0, 3'd3, 6'h3F);
    single("empty_xor",  BASE, '0, 3'd4, 6'h00);
    single("empty_nand", BASE, '0, 3'd1, 6'h00);

    single("full_and",  BASE, FULL, 3'd0, 6'h02);
    single("full_or",   BASE, FULL, 3'd2, 6'h3E);
    single("full_xnor", BASE, FULL, 3'd5, 6'h31);
    single("buf_nomask", BASE, '0, 3'd6, 6'h26);
    single("not_nomask", BASE, '0, 3'd7, 6'h19);

    xcase("x_nor_x1", 3'd3, 5'b00011, 5'b00001, 5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    xcase("x_nor_x0", 3'd3, 5'b00011, 5'b00000, 5'b00010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    xcase("z_and_z0", 3'd0, 5'b00011, 5'b00000, 5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    xcase("x_xor_x0", 3'd4, 5'b00011, 5'b00000, 5'b00010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    xcase("x_masked", 3'd3, 5'b00001, 5'b00000, 5'b00010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // throughput: 10 back-to-back beats, output expected on cycles 1..10 after first edge
    out_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        in_valid = 1'b1;
        in_data  = BASE;
        in_mask  = FULL;
        in_op    = 3'(i % 8);
        exp_q.push_back({3'(i % 8), exp_tab[i % 8]});
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 10) check("tput/in_ready", in_ready, 1'b1);
      tick();
      check("tput/out_valid", out_valid, (i >= 1 && i <= 10) ? 1'b1 : 1'b0);
      if (out_valid && exp_q.size() != 0) check("tput/result", {out_op, out_data}, exp_q.pop_front());
    end
    check("tput/all_out", exp_q.size(), 0);

    // backpressure: only two entries fit while out_ready is low
    out_ready = 1'b0;
    n_out     = 0;
    enqueue(3'd2);
    enqueue(3'd4);
    enqueue(3'd6);
    enqueue(3'd7);
    for (int j = 0; j < 4; j++) begin
      step();
      if (j >= 1) begin
        check("bp/held_valid", out_valid, 1'b1);
        check("bp/held_data", out_data, 6'h3E);
        check("bp/held_op", out_op, 3'd2);
      end
    end
    check("bp/accepted", 4 - pend_q.size(), 2);
    check("bp/in_ready", in_ready, 1'b0);
    check("bp/busy", busy, 1'b1);
    out_ready = 1'b1;
    for (int j = 0; j < 20 && (pend_q.size() != 0 || exp_q.size() != 0); j++) step();
    check("bp/drained", exp_q.size(), 0);
    check("bp/out_count", n_out, 4);
    check("bp/idle_valid", out_valid, 1'b0);
    check("bp/idle_busy", busy, 1'b0);

    // reset while stalled with two entries in flight
    out_ready = 1'b0;
    enqueue(3'd0);
    enqueue(3'd1);
    step();
    step();
    check("mrst/loaded", pend_q.size(), 0);
    check("mrst/busy_before", busy, 1'b1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("mrst/out_valid", out_valid, 1'b0);
    check("mrst/busy", busy, 1'b0);
    check("mrst/out_data", out_data, 6'h00);
    check("mrst/out_op", out_op, 3'd0);
    rst_n = 1'b1;
    exp_q.delete();
    #1;
    check("mrst/in_ready", in_ready, 1'b1);
    single("mrst_after", BASE, FULL, 3'd4, 6'h0E);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("mrst/no_ghost", out_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
